step_dir_decoder: RTL and testbench



---
 rtl/step_dir_decoder.sv | 207 ++++++++++++++++++++
 tb/tb_step_dir_decoder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/step_dir_decoder.sv
// STEP/DIR receiver: synchronizes the lines, tracks a signed axis position, measures the step
// period and flags A4988 timing violations. Define STEP_TIMEOUT_EN to add the stall detector.
module step_dir_decoder #(
    parameter int unsigned POS_W       = 32,
    parameter int unsigned PERIOD_W    = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DIR_SETUP   = 10,
    parameter int unsigned MIN_HIGH    = 50
`ifdef STEP_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                step_in,
    input  logic                dir_in,
    input  logic                clear_pos,
    input  logic                err_clear,
    input  logic [POS_W-1:0]    target_pos,
    output logic [POS_W-1:0]    position,
    output logic                step_pulse,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid,
    output logic                at_target,
    output logic                err_setup,
    output logic                err_width,
    output logic                stalled
);

    localparam int unsigned HwW  = $clog2(MIN_HIGH + 2);
    localparam int unsigned DirW = $clog2(DIR_SETUP + 2);
    localparam logic [HwW-1:0]  HwMax  = HwW'(MIN_HIGH);
    localparam logic [DirW-1:0] DirMax = DirW'(DIR_SETUP);

    typedef enum logic [0:0] {StLow, StHigh} state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] step_sync_q, dir_sync_q;
    logic                   s_step, s_dir;
    logic                   step_prev_q, dir_prev_q;
    logic                   rise, dir_change;
    logic [DirW-1:0]        dir_cnt_q, dir_cnt_cur;
    logic [HwW-1:0]         hw_cnt_q;
    logic [PERIOD_W-1:0]    per_cnt_q, per_next;
    logic                   seen_rise_q;
    logic                   count_step, width_viol, setup_viol;

    logic [POS_W-1:0]       position_q;
    logic                   step_pulse_q, at_target_q, err_setup_q, err_width_q;
    logic [PERIOD_W-1:0]    period_q;
    logic                   period_valid_q;

    // Synchronizers and edge history run even while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_sync_q <= '0;
            dir_sync_q  <= '0;
            step_prev_q <= 1'b0;
            dir_prev_q  <= 1'b0;
        end else begin
            step_sync_q <= {step_sync_q[SYNC_STAGES-2:0], step_in};
            dir_sync_q  <= {dir_sync_q[SYNC_STAGES-2:0], dir_in};
            step_prev_q <= s_step;
            dir_prev_q  <= s_dir;
        end
    end

    assign s_step     = step_sync_q[SYNC_STAGES-1];
    assign s_dir      = dir_sync_q[SYNC_STAGES-1];
    assign rise       = s_step & ~step_prev_q;
    assign dir_change = s_dir ^ dir_prev_q;

    // Cycles s_dir has been stable, counting the change cycle itself as zero.
    assign dir_cnt_cur = dir_change ? '0 : dir_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_cnt_q <= '0;
        end else if (dir_cnt_cur < DirMax) begin
            dir_cnt_q <= dir_cnt_cur + 1'b1;
        end else begin
            dir_cnt_q <= dir_cnt_cur;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StLow;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = StLow;
        end else begin
            unique case (state_q)
                StLow:   if (rise && !clear_pos) state_d = StHigh;
                StHigh:  if (!s_step) state_d = StLow;
                default: state_d = StLow;
            endcase
        end
    end

    always_comb begin
        count_step = 1'b0;
        width_viol = 1'b0;
        if (enable) begin
            unique case (state_q)
                StLow:   count_step = rise & ~clear_pos;
                StHigh:  width_viol = ~s_step & (hw_cnt_q < HwMax);
                default: ;
            endcase
        end
    end

    assign setup_viol = count_step & (dir_cnt_cur < DirMax);

    // The rise cycle itself counts as the first high cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hw_cnt_q <= '0;
        end else if (count_step) begin
            hw_cnt_q <= HwW'(1);
        end else if (state_q == StHigh) begin
            if (s_step && (hw_cnt_q < HwMax)) hw_cnt_q <= hw_cnt_q + 1'b1;
        end else begin
            hw_cnt_q <= '0;
        end
    end

    assign per_next = (per_cnt_q == '1) ? per_cnt_q : per_cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_cnt_q      <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            seen_rise_q    <= 1'b0;
        end else if (!enable || clear_pos) begin
            per_cnt_q      <= '0;
            period_valid_q <= 1'b0;
            seen_rise_q    <= 1'b0;
        end else if (count_step) begin
            per_cnt_q      <= '0;
            period_q       <= per_next;
            period_valid_q <= seen_rise_q;
            seen_rise_q    <= 1'b1;
        end else begin
            per_cnt_q      <= per_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            position_q   <= '0;
            step_pulse_q <= 1'b0;
            at_target_q  <= 1'b0;
            err_setup_q  <= 1'b0;
            err_width_q  <= 1'b0;
        end else begin
            step_pulse_q <= count_step;
            if (clear_pos) begin
                position_q <= '0;
            end else if (count_step) begin
                position_q <= s_dir ? position_q + 1'b1 : position_q - 1'b1;
            end
            at_target_q <= (position_q == target_pos);
            err_setup_q <= setup_viol | (err_setup_q & ~err_clear);
            err_width_q <= width_viol | (err_width_q & ~err_clear);
        end
    end

`ifdef STEP_TIMEOUT_EN
    localparam logic [PERIOD_W-1:0] TimeoutCnt = PERIOD_W'(TIMEOUT_CYCLES);

    logic stalled_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stalled_q <= 1'b0;
        end else if (!enable || clear_pos || count_step) begin
            stalled_q <= 1'b0;
        end else if (seen_rise_q && (per_cnt_q >= TimeoutCnt)) begin
            stalled_q <= 1'b1;
        end
    end

    assign stalled = stalled_q;
`else
    assign stalled = 1'b0;
`endif

    assign position     = position_q;
    assign step_pulse   = step_pulse_q;
    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign at_target    = at_target_q;
    assign err_setup    = err_setup_q;
    assign err_width    = err_width_q;

endmodule

// File: tb/tb_step_dir_decoder.sv
// Bench for step_dir_decoder: directed scenarios plus random steps, scoreboard-checked strobes.
module tb_step_dir_decoder;

    logic        clk = 1'b0;
    logic        rst_n, enable, step_in, dir_in, clear_pos, err_clear;
    logic [31:0] target_pos, position, period;
    logic        step_pulse, period_valid, at_target, err_setup, err_width, stalled;
    logic [3:0]  target_pos_s, position_s;
    logic [31:0] period_s;
    logic        step_pulse_s, period_valid_s, at_target_s, err_setup_s, err_width_s, stalled_s;

    step_dir_decoder #(
        .POS_W(32)
`ifdef STEP_TIMEOUT_EN
        , .TIMEOUT_CYCLES(1000)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .step_in(step_in), .dir_in(dir_in),
        .clear_pos(clear_pos), .err_clear(err_clear), .target_pos(target_pos),
        .position(position), .step_pulse(step_pulse), .period(period),
        .period_valid(period_valid), .at_target(at_target), .err_setup(err_setup),
        .err_width(err_width), .stalled(stalled)
    );

    // Narrow instance so the wrap from most-positive to most-negative is reachable.
    step_dir_decoder #(.POS_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .enable(enable), .step_in(step_in), .dir_in(dir_in),
        .clear_pos(clear_pos), .err_clear(err_clear), .target_pos(target_pos_s),
        .position(position_s), .step_pulse(step_pulse_s), .period(period_s),
        .period_valid(period_valid_s), .at_target(at_target_s), .err_setup(err_setup_s),
        .err_width(err_width_s), .stalled(stalled_s)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        logic [31:0] pos;
        logic        pv;
        logic [31:0] per;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          pulses = 0;

    // Reference model state
    logic [31:0] exp_pos = '0;
    int unsigned last_rise = 0;
    int unsigned nrise = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && step_pulse) begin
            pulses++;
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_step_pulse: got pulse expected none (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("pulse_cycle", 64'(cyc), 64'(mon_e.cyc));
                check("pulse_position", 64'(position), 64'(mon_e.pos));
                check("pulse_period_valid", 64'(period_valid), 64'(mon_e.pv));
                if (mon_e.pv) check("pulse_period", 64'(period), 64'(mon_e.per));
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Raises step_in and records the step the decoder must report 3 cycles later.
    task automatic rise_counted();
        exp_t e;
        exp_pos   = dir_in ? exp_pos + 32'd1 : exp_pos - 32'd1;
        e.cyc     = cyc + 3;
        e.pos     = exp_pos;
        e.pv      = (nrise > 0);
        e.per     = cyc - last_rise;
        last_rise = cyc;
        nrise++;
        sb.push_back(e);
        step_in = 1'b1;
    endtask

    task automatic do_step(input logic dir, input int lead, input int high, input int low);
        dir_in = dir;
        wait_cyc(lead);
        rise_counted();
        wait_cyc(high);
        step_in = 1'b0;
        wait_cyc(low);
    endtask

    task automatic pulse_err_clear();
        err_clear = 1'b1;
        wait_cyc(1);
        err_clear = 1'b0;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; enable = 1'b0; step_in = 1'b0; dir_in = 1'b1;
        clear_pos = 1'b0; err_clear = 1'b0; target_pos = 32'h1234; target_pos_s = 4'h3;
        repeat (3) @(negedge clk);
        check("rst_position", 64'(position), 64'd0);
        check("rst_step_pulse", 64'(step_pulse), 64'd0);
        check("rst_period", 64'(period), 64'd0);
        check("rst_period_valid", 64'(period_valid), 64'd0);
        check("rst_at_target", 64'(at_target), 64'd0);
        check("rst_err_setup", 64'(err_setup), 64'd0);
        check("rst_err_width", 64'(err_width), 64'd0);
        check("rst_stalled", 64'(stalled), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        enable = 1'b1;

        // Five steps up, 120-cycle period
        wait_cyc(100);
        for (int i = 0; i < 5; i++) do_step(1'b1, 0, 60, 60);
        check("t1_position", 64'(position), 64'd5);
        check("t1_pulses", 64'(pulses), 64'd5);
        check("t1_period", 64'(period), 64'd120);
        check("t1_period_valid", 64'(period_valid), 64'd1);

        // Dir setup: exactly DIR_SETUP cycles passes, 4 cycles fails
        do_step(1'b0, 10, 60, 20);
        check("t2_setup_boundary_ok", 64'(err_setup), 64'd0);
        do_step(1'b1, 4, 60, 20);
        check("t2_setup_err", 64'(err_setup), 64'd1);
        check("t2_position", 64'(position), 64'(exp_pos));
        pulse_err_clear();
        @(negedge clk);
        check("t2_setup_cleared", 64'(err_setup), 64'd0);
        @(posedge clk); #1;

        // High width: 50 is legal, 20 is short
        do_step(1'b1, 12, 50, 20);
        check("t3_width_boundary_ok", 64'(err_width), 64'd0);
        do_step(1'b1, 0, 20, 20);
        check("t3_width_err", 64'(err_width), 64'd1);
        check("t3_position", 64'(position), 64'(exp_pos));
        pulse_err_clear();
        check("t3_width_cleared", 64'(err_width), 64'd0);

        // clear_pos in the same cycle as the synchronized rise
        step_in = 1'b1;
        wait_cyc(2);
        clear_pos = 1'b1;
        wait_cyc(1);
        clear_pos = 1'b0;
        exp_pos = '0;
        nrise = 0;
        @(negedge clk);
        check("t5_no_pulse", 64'(step_pulse), 64'd0);
        check("t5_position", 64'(position), 64'd0);
        check("t5_period_valid", 64'(period_valid), 64'd0);
        check("t5_position_s", 64'(position_s), 64'd0);
        @(posedge clk); #1;
        wait_cyc(60);
        step_in = 1'b0;
        wait_cyc(20);

        // Wrap on the 4-bit instance: 7 -> 8 (most negative), at_target one cycle later
        for (int i = 0; i < 7; i++) do_step(1'b1, 0, 55, 5);
        check("t4_pos_s_max", 64'(position_s), 64'd7);
        target_pos_s = 4'h8;
        target_pos = exp_pos + 32'd1;
        wait_cyc(3);
        rise_counted();
        repeat (4) @(negedge clk);
        check("t4_pos_s_wrap", 64'(position_s), 64'h8);
        check("t4_at_target_s_lag", 64'(at_target_s), 64'd0);
        check("t4_at_target_lag", 64'(at_target), 64'd0);
        @(negedge clk);
        check("t4_at_target_s", 64'(at_target_s), 64'd1);
        check("t4_at_target", 64'(at_target), 64'd1);
        @(posedge clk); #1;
        wait_cyc(60);
        step_in = 1'b0;
        wait_cyc(20);
        target_pos = 32'h1234;

        // Re-enable while step is already high: nothing counted
        enable = 1'b0;
        wait_cyc(2);
        step_in = 1'b1;
        wait_cyc(10);
        enable = 1'b1;
        nrise = 0;
        wait_cyc(20);
        check("t6_position", 64'(position), 64'(exp_pos));
        check("t6_period_valid", 64'(period_valid), 64'd0);
        step_in = 1'b0;
        wait_cyc(20);

        // Random steps against the model
        for (int i = 0; i < 30; i++) begin
            do_step(1'($urandom_range(0, 1)), $urandom_range(12, 20), $urandom_range(50, 80),
                    $urandom_range(3, 30));
        end
        check("rand_position", 64'(position), 64'(exp_pos));
        check("rand_err_setup", 64'(err_setup), 64'd0);
        check("rand_err_width", 64'(err_width), 64'd0);

`ifdef STEP_TIMEOUT_EN
        do_step(1'b1, 12, 60, 1000);
        check("stall_set", 64'(stalled), 64'd1);
        do_step(1'b1, 0, 60, 20);
        check("stall_cleared", 64'(stalled), 64'd0);
`else
        check("stall_tied_low", 64'(stalled), 64'd0);
`endif

        wait_cyc(10);
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
